vga_fb_scheduler: RTL and testbench



---
 rtl/vga_fb_scheduler_if.sv | 41 ++++
 rtl/vga_fb_scheduler.sv | 165 ++++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_scheduler_if.sv
// Bus bundle for the frame-buffer scheduler: display FIFO port, pixel-writer
// handshake and the single-port SRAM pins.
interface vga_fb_scheduler_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 12
);
    // Display side
    logic                 vga_enable;
    logic                 pix_pop;
    logic                 pix_valid;
    logic [DATA_BITS-1:0] pix_data;
    logic                 underflow;

    // Pixel-writer handshake
    logic                 wr_req;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_ack;

    // SRAM pins
    logic [ADDR_BITS-1:0] sram_addr;
    logic [DATA_BITS-1:0] sram_data_out;
    logic [DATA_BITS-1:0] sram_data_in;
    logic                 sram_data_oe;
    logic                 sram_we_n;
    logic                 sram_oe_n;

    // Scheduler view
    modport master (
        output vga_enable, pix_valid, pix_data, underflow, wr_ack,
        output sram_addr, sram_data_out, sram_data_oe, sram_we_n, sram_oe_n,
        input  pix_pop, wr_req, wr_addr, wr_data, sram_data_in
    );

    // Peer view (display, writer and SRAM together)
    modport slave (
        input  vga_enable, pix_valid, pix_data, underflow, wr_ack,
        input  sram_addr, sram_data_out, sram_data_oe, sram_we_n, sram_oe_n,
        output pix_pop, wr_req, wr_addr, wr_data, sram_data_in
    );
endinterface

// File: rtl/vga_fb_scheduler.sv
// Frame-buffer scheduler: prefetches pixels from a single-port SRAM into a
// first-word-fall-through FIFO ahead of the raster, gates the raster until the
// FIFO is primed, and lets a pixel writer use the bus when the display can wait.
module vga_fb_scheduler #(
    parameter int ADDR_BITS  = 20,
    parameter int DATA_BITS  = 12,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8,
    parameter int LOW_WATER  = 4
) (
    input  logic               clk,
    input  logic               reset,
    vga_fb_scheduler_if.master bus
);
    localparam int PIXELS   = H_VISIBLE * V_VISIBLE;
    localparam int FA_BITS  = $clog2(PIXELS);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int OCC_BITS = CNT_BITS + 1;

    typedef enum logic {ST_PREFILL, ST_RUN} state_t;

    state_t               state_q;
    logic                 vga_enable_q;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 underflow_q;

    // Read tracker: bit 0 = read on the pins this cycle, bit 2 = its data is
    // on sram_data_in this cycle and gets pushed at the closing edge.
    logic [2:0]           rd_pipe_q;
    logic [FA_BITS-1:0]   fetch_addr_q, fetch_addr_d;

    logic [ADDR_BITS-1:0] sram_addr_q;
    logic [DATA_BITS-1:0] sram_data_out_q;
    logic                 sram_data_oe_q, sram_we_n_q, sram_oe_n_q, wr_ack_q;

    logic [1:0]           inflight;
    logic [OCC_BITS-1:0]  occ;
    logic                 grant_rd, grant_wr, push, pop;

    assign inflight = {1'b0, rd_pipe_q[0]} + {1'b0, rd_pipe_q[1]} + {1'b0, rd_pipe_q[2]};
    assign occ      = OCC_BITS'(count_q) + OCC_BITS'(inflight);
    assign push     = rd_pipe_q[2];
    assign pop      = bus.pix_pop && (count_q != '0);

    // Bus arbitration. A read is blocked for one cycle after a write is on the
    // pins; a write is blocked while a read or the previous write (still being
    // acknowledged, so wr_req is legitimately still high) is on the pins.
    always_comb begin
        grant_rd = (occ < OCC_BITS'(FIFO_DEPTH)) && !wr_ack_q &&
                   ((occ < OCC_BITS'(LOW_WATER)) || !bus.wr_req);
        grant_wr = !grant_rd && bus.wr_req && !wr_ack_q && !rd_pipe_q[0];
    end

    // Linear fetch address with wrap at the end of the visible frame
    always_comb begin
        fetch_addr_d = fetch_addr_q + FA_BITS'(1);
        if (fetch_addr_q == FA_BITS'(PIXELS - 1)) begin
            fetch_addr_d = '0;
        end
    end

    // FIFO occupancy: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    // Prefill/run sequencer; once running it stays running until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PREFILL;
            vga_enable_q <= 1'b0;
        end else begin
            case (state_q)
                ST_PREFILL: begin
                    if (count_q >= CNT_BITS'(PREFILL)) begin
                        state_q      <= ST_RUN;
                        vga_enable_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    vga_enable_q <= 1'b1;
                end
            endcase
        end
    end

    // FIFO storage; entries are only meaningful below count_q, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.sram_data_in;
        end
    end

    // FIFO pointers, occupancy and the sticky underflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            count_q <= count_d;
            if (bus.pix_pop && (count_q == '0)) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Registered SRAM pins, read tracker and fetch address; reset drops any
    // reads still in flight so their returning data is never pushed
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe_q       <= '0;
            fetch_addr_q    <= '0;
            sram_addr_q     <= '0;
            sram_data_out_q <= '0;
            sram_data_oe_q  <= 1'b0;
            sram_we_n_q     <= 1'b1;
            sram_oe_n_q     <= 1'b1;
            wr_ack_q        <= 1'b0;
        end else begin
            rd_pipe_q      <= {rd_pipe_q[1:0], grant_rd};
            sram_oe_n_q    <= !grant_rd;
            sram_we_n_q    <= !grant_wr;
            sram_data_oe_q <= grant_wr;
            wr_ack_q       <= grant_wr;
            if (grant_rd) begin
                sram_addr_q  <= ADDR_BITS'(fetch_addr_q);
                fetch_addr_q <= fetch_addr_d;
            end else if (grant_wr) begin
                sram_addr_q     <= bus.wr_addr;
                sram_data_out_q <= bus.wr_data;
            end
        end
    end

    assign bus.vga_enable    = vga_enable_q;
    assign bus.pix_valid     = (count_q != '0);
    assign bus.pix_data      = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    assign bus.underflow     = underflow_q;
    assign bus.wr_ack        = wr_ack_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_data_out = sram_data_out_q;
    assign bus.sram_data_oe  = sram_data_oe_q;
    assign bus.sram_we_n     = sram_we_n_q;
    assign bus.sram_oe_n     = sram_oe_n_q;
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler (16x4 visible frame): an SRAM model with fixed
// read latency, a raster/random pixel consumer, a random writer and a
// queue-based reference of the FIFO contents and bus arbitration rules.
module tb_vga_fb_scheduler;
    localparam int AB    = 8;
    localparam int DB    = 12;
    localparam int HV    = 16;
    localparam int VV    = 4;
    localparam int PIX   = HV * VV;
    localparam int DEPTH = 16;
    localparam int PRE   = 8;
    localparam int LOWW  = 4;
    localparam int HTOT  = 24;
    localparam int VTOT  = 6;

    typedef struct {
        int            cyc;
        logic [DB-1:0] val;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_fb_scheduler_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus_if ();

    vga_fb_scheduler #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .H_VISIBLE(HV), .V_VISIBLE(VV),
        .FIFO_DEPTH(DEPTH), .PREFILL(PRE), .LOW_WATER(LOWW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    int checks   = 0;
    int failures = 0;

    // Environment and reference state
    logic [DB-1:0] mem [256];
    ent_t          bus_q[$];   // SRAM model pipeline, survives DUT reset
    ent_t          pend[$];    // expected in-flight reads
    logic [DB-1:0] fq[$];      // expected FIFO contents
    int  cyc = 0;
    int  exp_addr = 0;
    bit  pred_rd = 0, pred_wr = 0, uf_m = 0, en_m = 0;
    bit  after_reset = 1, ack_prev = 0, rst_now = 0, wr_en = 0;
    int  pop_mode = 0, pop_thr = 0;
    int  col = 0, row = 0, seq = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check outputs, run the SRAM model, drive inputs, advance the reference
    task automatic step();
        int  occ;
        bit  nrd, nwr;
        @(posedge clk);
        #1;
        cyc++;
        while (pend.size() > 0 && pend[0].cyc <= cyc - 3) begin
            fq.push_back(pend[0].val);
            void'(pend.pop_front());
        end

        chk("sram_oe_n", bus_if.sram_oe_n, !pred_rd);
        chk("sram_we_n", bus_if.sram_we_n, !pred_wr);
        chk("wr_ack", bus_if.wr_ack, pred_wr);
        chk("sram_data_oe", bus_if.sram_data_oe, pred_wr);
        if (pred_rd) begin
            chk("rd_addr", bus_if.sram_addr, exp_addr);
            pend.push_back('{cyc, mem[exp_addr]});
            exp_addr = (exp_addr + 1) % PIX;
        end
        if (pred_wr) begin
            chk("wr_pin_addr", bus_if.sram_addr, bus_if.wr_addr);
            chk("wr_pin_data", bus_if.sram_data_out, bus_if.wr_data);
        end
        if (after_reset) begin
            chk("rst_sram_addr", bus_if.sram_addr, 0);
            chk("rst_sram_data_out", bus_if.sram_data_out, 0);
        end
        chk("pix_valid", bus_if.pix_valid, fq.size() > 0);
        chk("pix_data", bus_if.pix_data, (fq.size() > 0) ? fq[0] : '0);
        chk("underflow", bus_if.underflow, uf_m);
        chk("vga_enable", bus_if.vga_enable, en_m);
        if (fq.size() >= PRE) en_m = 1;

        // SRAM model: data for a read on the pins in cycle D is driven in D+2
        if (!bus_if.sram_oe_n) bus_q.push_back('{cyc, mem[bus_if.sram_addr]});
        if (!bus_if.sram_we_n) mem[bus_if.sram_addr] = bus_if.sram_data_out;
        while (bus_q.size() > 0 && bus_q[0].cyc < cyc - 2) void'(bus_q.pop_front());
        if (bus_q.size() > 0 && bus_q[0].cyc == cyc - 2) bus_if.sram_data_in = bus_q[0].val;
        else bus_if.sram_data_in = DB'($urandom);

        // Writer: holds a request until acknowledged, may change the cycle after
        if (wr_en) begin
            if (!bus_if.wr_req || ack_prev) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus_if.wr_req  = 1'b1;
                    bus_if.wr_addr = AB'($urandom);
                    bus_if.wr_data = DB'($urandom);
                end else begin
                    bus_if.wr_req = 1'b0;
                end
            end
        end else begin
            bus_if.wr_req = 1'b0;
        end
        ack_prev = pred_wr;

        // Consumer
        case (pop_mode)
            1:       bus_if.pix_pop = 1'b1;
            2:       bus_if.pix_pop = bus_if.vga_enable && (col < HV) && (row < VV);
            3:       bus_if.pix_pop = ($urandom_range(0, 3) < pop_thr);
            default: bus_if.pix_pop = 1'b0;
        endcase
        if (pop_mode == 2 && bus_if.pix_pop) begin
            chk("pop_seq", bus_if.pix_data, seq % PIX);
            seq++;
        end
        if (pop_mode == 2 && bus_if.vga_enable) begin
            col = (col + 1) % HTOT;
            if (col == 0) row = (row + 1) % VTOT;
        end
        reset = rst_now;

        // Arbitration reference for the next cycle's pins
        occ = fq.size() + pend.size();
        nrd = (occ < DEPTH) && !pred_wr && ((occ < LOWW) || !bus_if.wr_req);
        nwr = !nrd && bus_if.wr_req && !pred_wr && !pred_rd;

        if (rst_now) begin
            fq.delete();
            pend.delete();
            uf_m = 0; en_m = 0; exp_addr = 0;
            pred_rd = 0; pred_wr = 0;
        end else begin
            if (bus_if.pix_pop) begin
                if (fq.size() > 0) void'(fq.pop_front());
                else uf_m = 1;
            end
            pred_rd = nrd;
            pred_wr = nwr;
        end
        after_reset = rst_now;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = DB'(i);
        reset = 1'b1;
        bus_if.pix_pop = 1'b0;
        bus_if.wr_req = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        bus_if.sram_data_in = '0;
        repeat (2) @(posedge clk);

        // Reset state, then prefill and three frames of raster-driven display
        rst_now = 1; step();
        rst_now = 0;
        pop_mode = 2;
        repeat (20 + 3 * HTOT * VTOT) step();
        chk("raster_no_underflow", bus_if.underflow, 0);
        chk("raster_enabled", bus_if.vga_enable, 1);

        // Writer contention: FIFO mostly full, then mostly drained
        pop_mode = 3; wr_en = 1;
        pop_thr = 1; repeat (700) step();
        pop_thr = 3; repeat (800) step();

        // Reset with reads in flight and the FIFO at 10
        wr_en = 0; pop_mode = 0;
        rst_now = 1; step(); rst_now = 0;
        n = 0;
        while (fq.size() != 10 && n < 60) begin step(); n++; end
        checks++;
        if (fq.size() != 10) begin
            failures++;
            $display("FAIL fill_to_10 observed=%0d expected=10", fq.size());
        end
        rst_now = 1; step(); rst_now = 0;
        repeat (40) step();

        // Full FIFO: no reads while room is 0, then push/pop around 15
        pop_mode = 3; pop_thr = 2;
        repeat (200) step();

        // Forced underflow straight out of reset
        pop_mode = 0;
        rst_now = 1; step(); rst_now = 0;
        pop_mode = 1;
        repeat (30) step();
        chk("underflow_sticky", bus_if.underflow, 1);
        pop_mode = 0;
        repeat (10) step();
        chk("underflow_held", bus_if.underflow, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
